// File: rtl/common_params.sv
// Shared fetch/execute types: micro-instruction format, opcode set, bundle width.
package common_params;

   localparam int MQ_N  = 4;
   localparam int MQ_KW = $clog2(MQ_N + 1);

   typedef enum logic [2:0] {
      MIOP_NOP   = 3'd0,
      MIOP_ADDI  = 3'd1,
      MIOP_STORE = 3'd2,
      MIOP_LOAD  = 3'd3,
      MIOP_PUSH  = 3'd4,
      MIOP_POP   = 3'd5,
      MIOP_JMP   = 3'd6,
      MIOP_ALU   = 3'd7
   } miop_t;

   typedef struct packed {
      miop_t       op;
      logic [15:0] pc;
      logic [3:0]  bmd;
   } miinst_t;

   function automatic miinst_t nop(input logic [15:0] pc);
      miinst_t m;
      m     = '0;
      m.op  = MIOP_NOP;
      m.pc  = pc;
      return m;
   endfunction

endpackage

// File: rtl/fetch_miinst_queue_pkg.sv
// Local parameters for fetch_miinst_queue: queue depth legality rule.
package fetch_miinst_queue_pkg;

   // Depth must be a power of two and hold at least two full bundles.
   function automatic bit depth_legal(input int depth, input int mq_n);
      return (depth >= 2 * mq_n) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/miinst_compactor.sv
// Combinational NOP squeezer: per-slot live flag, rank among live slots, live count.
// Zero latency; no flow control of its own.
module miinst_compactor
   import common_params::*;
(
   input  miinst_t [MQ_N-1:0]            bundle_i,
   output logic    [MQ_N-1:0]            live_o,
   output logic    [MQ_N-1:0][MQ_KW-1:0] rank_o,
   output logic    [MQ_KW-1:0]           k_o
);

   logic [MQ_KW-1:0] acc;

   always_comb begin
      acc    = '0;
      live_o = '0;
      rank_o = '0;
      for (int j = 0; j < MQ_N; j++) begin
         live_o[j] = (bundle_i[j].op != MIOP_NOP);
         rank_o[j] = acc;
         acc       = acc + MQ_KW'(live_o[j]);
      end
      k_o = acc;
   end

endmodule

// File: rtl/fetch_miinst_queue.sv
// Micro-instruction FIFO after the decoder; 1-cycle latency, in_ready/out_valid from registered count.
// Optional NOP squeezing with MIQ_NOP_SQUEEZE_EN; flush empties the queue and drops that cycle's bundle.
module fetch_miinst_queue
   import common_params::*;
   import fetch_miinst_queue_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  miinst_t [MQ_N-1:0]         miinst_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output miinst_t                    miinst_out,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (!depth_legal(DEPTH, MQ_N)) begin : g_bad_depth
      $error("fetch_miinst_queue: DEPTH must be a power of two and >= 2*MQ_N");
   end

   logic [PW-1:0]             head_q, head_d;
   logic [PW-1:0]             tail_q, tail_d;
   logic [CW-1:0]             count_q, count_d;
   miinst_t                   mem_q [DEPTH];

   logic [MQ_N-1:0]            live;
   logic [MQ_N-1:0][MQ_KW-1:0] rank;
   logic [MQ_KW-1:0]           k;
   logic [MQ_N-1:0][PW-1:0]    wr_idx;
   logic                       enq, deq;
   logic [MQ_KW-1:0]           k_eff;

`ifdef MIQ_NOP_SQUEEZE_EN
   miinst_compactor u_compactor (
      .bundle_i (miinst_in),
      .live_o   (live),
      .rank_o   (rank),
      .k_o      (k)
   );
`else
   always_comb begin
      live = '1;
      rank = '0;
      k    = MQ_KW'(MQ_N);
      for (int j = 0; j < MQ_N; j++) begin
         rank[j] = MQ_KW'(j);
      end
   end
`endif

   assign in_ready  = (count_q <= CW'(DEPTH - MQ_N));
   assign out_valid = (count_q != '0);
   assign count     = count_q;
   // Gate with out_valid so reset and empty states present a clean NOP.
   assign miinst_out = out_valid ? mem_q[head_q] : nop('0);

   always_comb begin
      enq     = in_valid && in_ready && !flush;
      deq     = out_valid && out_ready && !flush;
      k_eff   = enq ? k : '0;
      head_d  = head_q + PW'(deq);
      tail_d  = tail_q + PW'(k_eff);
      count_d = count_q + CW'(k_eff) - CW'(deq);
      wr_idx  = '0;
      for (int j = 0; j < MQ_N; j++) begin
         wr_idx[j] = tail_q + PW'(rank[j]);
      end
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed while count says they are valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         for (int j = 0; j < MQ_N; j++) begin
            if (live[j]) begin
               mem_q[wr_idx[j]] <= miinst_in[j];
            end
         end
      end
   end

endmodule
